// File: rtl/fibonacci_scheduler.sv
// fibonacci_scheduler: two-requester round-robin job scheduler streaming Fibonacci terms
// modulo 2^WIDTH, with valid/ready output handshake and per-job wrap flag.
module fibonacci_scheduler #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    input  logic [2*CNT_W-1:0] req_count,
    output logic [1:0]         req_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_id,
    output logic               out_last,
    output logic               out_ovf,
    output logic               busy
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;
    logic rr_q, rr_d, id_q, id_d, ovf_q, ovf_d, bw_q, bw_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0] rem_q, rem_d, cnt;
    logic gnt, accept, xfer;
    logic [WIDTH:0] sum;
    always_comb begin
        gnt       = (req_valid == 2'b11) ? rr_q : req_valid[1];
        cnt       = gnt ? req_count[CNT_W +: CNT_W] : req_count[0 +: CNT_W];
        req_ready = (!rst && state_q == IDLE && |req_valid) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
        accept    = |req_ready;
        out_valid = !rst && state_q == RUN;
        xfer      = out_valid && out_ready;
        sum       = {1'b0, a_q} + {1'b0, b_q};
        out_data  = out_valid ? a_q : '0;
        out_id    = out_valid && id_q;
        out_last  = out_valid && rem_q == CNT_W'(1);
        out_ovf   = out_valid && ovf_q;
        busy      = out_valid;
        state_d   = state_q;
        rr_d      = rr_q;
        id_d      = id_q;
        ovf_d     = ovf_q;
        bw_d      = bw_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        if (accept) begin
            rr_d = ~gnt;
            if (cnt != '0) begin
                a_d     = WIDTH'(1);
                b_d     = WIDTH'(1);
                rem_d   = cnt;
                id_d    = gnt;
                ovf_d   = 1'b0;
                bw_d    = 1'b0;
                state_d = RUN;
            end
        end
        // bw tracks a wrap sitting in b; it becomes visible once b shifts into a
        if (xfer) begin
            a_d   = b_q;
            b_d   = sum[WIDTH-1:0];
            rem_d = rem_q - CNT_W'(1);
            bw_d  = bw_q | sum[WIDTH];
            ovf_d = ovf_q | bw_q;
            if (rem_q == CNT_W'(1)) state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            id_q    <= 1'b0;
            ovf_q   <= 1'b0;
            bw_q    <= 1'b0;
            a_q     <= WIDTH'(1);
            b_q     <= WIDTH'(1);
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            ovf_q   <= ovf_d;
            bw_q    <= bw_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
        end
    end
endmodule
